// File: rtl/rnl_neuron_gen2.sv
// rnl_neuron_gen2
//   SRM0 ramp-no-leak neuron with per-synapse weight state, runtime threshold,
//   optional leak, spike-time capture and a gamma-boundary STDP weight update.
//   A computational wave runs from one grst pulse to the next.
//
// Ports
//   clk           unit clock
//   rst           synchronous active-high reset (loads w_init, clears all else)
//   grst          one-cycle gamma pulse marking the wave boundary
//   input_spikes  input pulses; a rising edge is the spike
//   w_init        weight load values, synapse i at [i*WRES +: WRES]
//   w_load        load w_init into the weights
//   inc / dec     STDP increment / decrement per synapse, applied on grst
//   thr           firing threshold; 0 disables firing
//   leak_en       enable a 1/edge leak when no ramp is active
//   weights       current synaptic weights
//   potential     membrane potential register
//   output_spike  output pulse, WMAX+1 cycles wide
//   spike_time    edges from grst to the output_spike rise
//   spike_valid   spike_time holds a valid value for this wave
module rnl_neuron_gen2 #(
  parameter int INP  = 16,
  parameter int WRES = 3,
  parameter int PRES = 8,
  parameter int TRES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 grst,
  input  logic [INP-1:0]       input_spikes,
  input  logic [INP*WRES-1:0]  w_init,
  input  logic                 w_load,
  input  logic [INP-1:0]       inc,
  input  logic [INP-1:0]       dec,
  input  logic [PRES-1:0]      thr,
  input  logic                 leak_en,
  output logic [INP*WRES-1:0]  weights,
  output logic [PRES-1:0]      potential,
  output logic                 output_spike,
  output logic [TRES-1:0]      spike_time,
  output logic                 spike_valid
);

  localparam int CW = $clog2(INP + 1);
  localparam logic [PRES:0] PSAT = {1'b0, {PRES{1'b1}}};

  logic [WRES-1:0] r_weight [INP];
  logic [WRES-1:0] r_ramp   [INP];
  logic            r_armed  [INP];
  logic [INP-1:0]  r_prev;
  logic [INP-1:0]  w_active;

  logic [PRES-1:0] r_pot;
  logic [TRES-1:0] r_tcnt;
  logic            r_fired;
  logic [WRES-1:0] r_pcnt;
  logic            r_out;
  logic [TRES-1:0] r_stime;
  logic            r_svalid;

  logic [CW-1:0]   w_pop;
  logic [PRES:0]   w_sum;
  logic [PRES-1:0] w_pot_next;
  logic [TRES-1:0] w_tcnt_next;
  logic            w_fire;

  genvar gi;
  generate
    for (gi = 0; gi < INP; gi++) begin : g_syn
      // Weights only move on w_load or at the wave boundary.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_weight[gi] <= w_init[gi*WRES +: WRES];
        end else if (w_load) begin
          r_weight[gi] <= w_init[gi*WRES +: WRES];
        end else if (grst) begin
          if (inc[gi] && !dec[gi] && (r_weight[gi] != '1))
            r_weight[gi] <= r_weight[gi] + WRES'(1);
          else if (dec[gi] && !inc[gi] && (r_weight[gi] != '0))
            r_weight[gi] <= r_weight[gi] - WRES'(1);
        end
      end

      // One accepted spike per wave: the ramp loads the weight, then drains
      // one unit per edge, contributing one unit of potential each time.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ramp[gi]  <= '0;
          r_armed[gi] <= 1'b0;
        end else if (grst) begin
          r_ramp[gi]  <= '0;
          r_armed[gi] <= 1'b1;
        end else if (r_armed[gi] && input_spikes[gi] && !r_prev[gi]) begin
          r_ramp[gi]  <= r_weight[gi];
          r_armed[gi] <= 1'b0;
        end else if (r_ramp[gi] != '0) begin
          r_ramp[gi]  <= r_ramp[gi] - WRES'(1);
        end
      end

      assign w_active[gi] = (r_ramp[gi] != '0);
      assign weights[gi*WRES +: WRES] = r_weight[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_prev <= '0;
    else     r_prev <= input_spikes;
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < INP; i++) w_pop = w_pop + CW'(w_active[i]);
  end

  // Saturating integrate; leak applies only on edges with no active ramp.
  always_comb begin
    w_sum      = {1'b0, r_pot} + (PRES+1)'(w_pop);
    w_pot_next = (w_sum > PSAT) ? '1 : w_sum[PRES-1:0];
    if (leak_en && (w_pop == '0) && (r_pot != '0))
      w_pot_next = r_pot - PRES'(1);
    w_tcnt_next = (r_tcnt == '1) ? r_tcnt : r_tcnt + TRES'(1);
    w_fire      = !r_fired && (thr != '0) && (w_pot_next >= thr);
  end

  always_ff @(posedge clk) begin
    if (rst || grst) begin
      // grst also truncates a pulse still in flight and wins over a fire.
      r_pot    <= '0;
      r_tcnt   <= '0;
      r_fired  <= 1'b0;
      r_pcnt   <= '0;
      r_out    <= 1'b0;
      r_stime  <= '0;
      r_svalid <= 1'b0;
    end else begin
      r_pot  <= w_pot_next;
      r_tcnt <= w_tcnt_next;
      if (w_fire) begin
        r_out    <= 1'b1;
        r_fired  <= 1'b1;
        r_pcnt   <= '1;
        r_stime  <= w_tcnt_next;
        r_svalid <= 1'b1;
      end else if (r_out) begin
        // Loaded with WMAX, falls on the edge that sees 0: WMAX+1 cycles high.
        if (r_pcnt == '0) r_out  <= 1'b0;
        else              r_pcnt <= r_pcnt - WRES'(1);
      end
    end
  end

  assign potential    = r_pot;
  assign output_spike = r_out;
  assign spike_time   = r_stime;
  assign spike_valid  = r_svalid;

endmodule
